// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN accelerator types and constants
package cnn_pkg;

    // Memory initialisation sequencer states
    typedef enum logic [1:0] {
        INIT_CLEAR  = 2'd0,
        INIT_VERIFY = 2'd1,
        INIT_DONE   = 2'd2
    } init_state_t;

    // Default value written to every RAM word during initialisation
    localparam logic [15:0] INIT_FILL_DEFAULT = 16'h0000;

endpackage

// File: rtl/mem_init_seq.sv
// rtl/mem_init_seq.sv - post-reset RAM fill sequencer; optional read-back check under MEM_INIT_VERIFY_EN
module mem_init_seq
    import cnn_pkg::*;
#(
    parameter int                ADDR_W = 10,
    parameter int                DATA_W = 16,
    parameter int                DEPTH  = 1024,
    parameter logic [DATA_W-1:0] FILL   = DATA_W'(INIT_FILL_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              init_done,
    output logic              init_err
);

    // One extra bit so a full 2^ADDR_W sweep ends on DEPTH instead of wrapping to 0
    localparam logic [ADDR_W:0] END_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT = (ADDR_W+1)'(1);

    init_state_t     state;
    logic [ADDR_W:0] cnt;

`ifdef MEM_INIT_VERIFY_EN
    logic err_acc;
    logic rd_mismatch;

    // Read data on the bus belongs to the read issued on the previous edge
    assign rd_mismatch = (mem_rdata != FILL);
`else
    logic unused_rdata;

    assign unused_rdata = ^mem_rdata;
`endif

    // Sequencer FSM: address sweep, optional read-back, done/restart handling
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT_CLEAR;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= FILL;
            busy      <= 1'b0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
`ifdef MEM_INIT_VERIFY_EN
            err_acc   <= 1'b0;
`endif
        end else begin
            mem_wdata <= FILL;
            case (state)
                INIT_CLEAR: begin
                    if (cnt != END_CNT) begin
                        // Issue the write for the current count
                        mem_we   <= 1'b1;
                        busy     <= 1'b1;
                        mem_addr <= cnt[ADDR_W-1:0];
                        cnt      <= cnt + ONE_CNT;
                    end else begin
                        // Last write already issued on the previous edge
                        mem_we <= 1'b0;
`ifdef MEM_INIT_VERIFY_EN
                        // Start the read-back directly so no idle cycle is lost
                        mem_re   <= 1'b1;
                        mem_addr <= '0;
                        cnt      <= ONE_CNT;
                        busy     <= 1'b1;
                        err_acc  <= 1'b0;
                        state    <= INIT_VERIFY;
`else
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                        cnt       <= '0;
                        state     <= INIT_DONE;
`endif
                    end
                end
`ifdef MEM_INIT_VERIFY_EN
                INIT_VERIFY: begin
                    if (cnt != END_CNT) begin
                        // Next read while checking the word returned for the previous one
                        mem_re   <= 1'b1;
                        mem_addr <= cnt[ADDR_W-1:0];
                        cnt      <= cnt + ONE_CNT;
                        err_acc  <= err_acc | rd_mismatch;
                    end else begin
                        // This edge samples the data of the final read
                        mem_re    <= 1'b0;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                        init_err  <= err_acc | rd_mismatch;
                        cnt       <= '0;
                        state     <= INIT_DONE;
                    end
                end
`endif
                INIT_DONE: begin
                    if (init_req) begin
                        // Restart takes effect on this very edge with the write to address 0
                        mem_we    <= 1'b1;
                        mem_re    <= 1'b0;
                        busy      <= 1'b1;
                        init_done <= 1'b0;
                        init_err  <= 1'b0;
                        mem_addr  <= '0;
                        cnt       <= ONE_CNT;
                        state     <= INIT_CLEAR;
`ifdef MEM_INIT_VERIFY_EN
                        err_acc   <= 1'b0;
`endif
                    end else begin
                        mem_we    <= 1'b0;
                        mem_re    <= 1'b0;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a fresh sweep
                    mem_we    <= 1'b0;
                    mem_re    <= 1'b0;
                    busy      <= 1'b0;
                    init_done <= 1'b0;
                    init_err  <= 1'b0;
                    cnt       <= '0;
                    state     <= INIT_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_init_seq.sv
// tb/tb_mem_init_seq.sv - self-checking bench for mem_init_seq (DEPTH=8, ADDR_W=3, FILL=0)
module tb_mem_init_seq;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              init_req = 1'b0;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              init_done;
    logic              init_err;

    int errors = 0;
    int checks = 0;

    logic              preload = 1'b1;
    logic              force_bad = 1'b0;
    logic [DATA_W-1:0] ram [DEPTH];
    logic [ADDR_W-1:0] exp_q [$];

    typedef struct {
        bit         rst;
        bit         req;
        bit         we;
        logic [2:0] addr;
        bit         busy;
        bit         done;
    } vec_t;

    vec_t vecs [21];

    mem_init_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .FILL   (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init_req  (init_req),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .init_done (init_done),
        .init_err  (init_err)
    );

    always #5 clk = ~clk;

    // RAM model: preload pattern, synchronous write; read data valid in the cycle after the read edge
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 16'hA5A5;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = (force_bad && mem_addr == 3'd5) ? 16'h0001 : ram[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit q);
        rst      = r;
        init_req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(3'(i));
    endtask

    task automatic expect_out(input string name, input bit we, input logic [2:0] addr,
                              input bit bsy, input bit done);
        check({name, ".we"},   mem_we,    we);
        check({name, ".addr"}, mem_addr,  addr);
        check({name, ".busy"}, busy,      bsy);
        check({name, ".done"}, init_done, done);
    endtask

    // Scoreboard pop on every write plus output invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (!preload) begin
            if (mem_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_write: unexpected write to addr %0d, expected none", mem_addr);
                end else begin
                    logic [ADDR_W-1:0] a;
                    a = exp_q.pop_front();
                    if (mem_addr !== a) begin
                        errors++;
                        $display("FAIL sb_write: addr %0d expected %0d", mem_addr, a);
                    end
                end
            end
            checks++;
            if (busy && init_done) begin
                errors++;
                $display("FAIL inv_busy_done: busy=%0b init_done=%0b required not both 1", busy, init_done);
            end
            checks++;
            if (mem_we && mem_re) begin
                errors++;
                $display("FAIL inv_we_re: mem_we=%0b mem_re=%0b required not both 1", mem_we, mem_re);
            end
`ifndef MEM_INIT_VERIFY_EN
            checks++;
            if (mem_re !== 1'b0 || init_err !== 1'b0) begin
                errors++;
                $display("FAIL inv_noverify: mem_re=%0b init_err=%0b required 0", mem_re, init_err);
            end
`endif
        end
    end

    initial begin
        int n;

        // Hold reset while the RAM preload settles
        step(1, 0);
        step(1, 0);
        preload = 1'b0;
        check("reset.wdata", mem_wdata, 16'h0000);
        check("reset.err",   init_err,  1'b0);
        check("reset.re",    mem_re,    1'b0);

`ifndef MEM_INIT_VERIFY_EN
        // Test 1: 10 reset cycles, 8 writes, then done
        for (int i = 0; i < 21; i++) begin
            if (i < 10)      vecs[i] = '{1, 0, 0, 3'd0, 0, 0};
            else if (i < 18) vecs[i] = '{0, 0, 1, 3'(i - 10), 1, 0};
            else             vecs[i] = '{0, 0, 0, 3'd7, 0, 1};
        end
        push_sweep();
        for (int i = 0; i < 21; i++) begin
            step(vecs[i].rst, vecs[i].req);
            expect_out($sformatf("t1[%0d]", i), vecs[i].we, vecs[i].addr, vecs[i].busy, vecs[i].done);
        end
        for (int i = 0; i < DEPTH; i++) check($sformatf("t1.ram[%0d]", i), ram[i], 16'h0000);

        // Test 2: reset asserted at the 4th write edge for 2 cycles
        step(1, 0);
        push_sweep();
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            expect_out("t2.pre", 1, 3'(i), 1, 0);
        end
        step(1, 0);
        expect_out("t2.rst0", 0, 3'd0, 0, 0);
        check("t2.pending", exp_q.size(), 5);
        exp_q.delete();
        step(1, 0);
        expect_out("t2.rst1", 0, 3'd0, 0, 0);
        push_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0);
            expect_out("t2.sweep", 1, 3'(i), 1, 0);
        end
        step(0, 0);
        expect_out("t2.done", 0, 3'd7, 0, 1);

        // Test 3: request while busy is ignored; request in DONE restarts
        step(1, 0);
        push_sweep();
        step(0, 0);
        step(0, 1);
        expect_out("t3.ign", 1, 3'd1, 1, 0);
        for (int i = 2; i < DEPTH; i++) step(0, 0);
        step(0, 0);
        expect_out("t3.done", 0, 3'd7, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0);
        check("t3.still_done", init_done, 1'b1);
        push_sweep();
        step(0, 1);
        expect_out("t3.req", 1, 3'd0, 1, 0);
        n = 0;
        while (!init_done && n < 20) begin
            step(0, 0);
            n++;
        end
        check("t3.done_latency", n, 8);

        // Test 4: request held high gives back-to-back sweeps with one done cycle
        for (int s = 0; s < 3; s++) begin
            push_sweep();
            for (int i = 0; i < DEPTH; i++) begin
                step(0, 1);
                expect_out($sformatf("t4.s%0d", s), 1, 3'(i), 1, 0);
            end
            step(0, 1);
            expect_out($sformatf("t4.d%0d", s), 0, 3'd7, 0, 1);
        end
        step(0, 0);
        expect_out("t4.idle", 0, 3'd7, 0, 1);
`else
        // Verify build: address 5 reads back corrupted
        force_bad = 1'b1;
        push_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0);
            expect_out("v1.wr", 1, 3'(i), 1, 0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0);
            expect_out("v1.rd", 0, 3'(i), 1, 0);
            check("v1.re", mem_re, 1'b1);
        end
        step(0, 0);
        expect_out("v1.done", 0, 3'd7, 0, 1);
        check("v1.err", init_err, 1'b1);
        check("v1.re_off", mem_re, 1'b0);
        step(0, 0);
        check("v1.err_sticky", init_err, 1'b1);

        // Clean re-run via request: error clears on the request edge
        force_bad = 1'b0;
        push_sweep();
        step(0, 1);
        expect_out("v2.req", 1, 3'd0, 1, 0);
        check("v2.err_clr", init_err, 1'b0);
        n = 0;
        while (!init_done && n < 40) begin
            step(0, 0);
            n++;
        end
        check("v2.done_latency", n, 16);
        check("v2.err", init_err, 1'b0);
`endif

        step(0, 0);
        check("sb.empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
